spi_slave_rx_tx: RTL and testbench

SPI responder (slave) for the far end of the SoC's spi0/spi1 master ports. It oversamples the SPI pins in the system clock domain and deserialises MOSI into bytes. It serialises bytes from a valid/ready source onto MISO. It serves as a synthesizable flash/peripheral stand-in on the bench and as an FPGA-side link partner for the core.

---
 rtl/spi_slave_rx_tx.sv | 209 ++++++++++++++++++++
 tb/tb_spi_slave_rx_tx.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_tx.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_rx_tx
// Description : SPI mode-0 responder. Oversamples ss/sclk/mosi in the clk
//               domain, deserialises MOSI into DW-bit words (rx_valid strobe)
//               and serialises words from a valid/ready source onto MISO,
//               falling back to DEF_TX when no word is offered.
//               Optional macro SPI_SLV_LSB_FIRST_EN selects LSB-first order
//               in both directions (default build is MSB-first).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_rx_tx #(
   parameter int            DW     = 8,
   parameter logic [DW-1:0] DEF_TX = '1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          spi_ss,
   input  logic          spi_clk,
   input  logic          spi_mosi,
   output logic          spi_miso,
   output logic          spi_miso_oe,
   output logic [DW-1:0] rx_data,
   output logic          rx_valid,
   input  logic [DW-1:0] tx_data,
   input  logic          tx_valid,
   output logic          tx_ready,
   output logic          busy
);

   localparam int            CW       = (DW > 2) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

   typedef enum logic [1:0] {
      ST_WAIT_IDLE = 2'd0,
      ST_IDLE      = 2'd1,
      ST_ACTIVE    = 2'd2
   } state_t;

   state_t          state_q,    state_d;
   logic            ss_s1_q,    ss_s1_d;
   logic            ss_s2_q,    ss_s2_d;
   logic            ss_s3_q,    ss_s3_d;
   logic            sclk_s1_q,  sclk_s1_d;
   logic            sclk_s2_q,  sclk_s2_d;
   logic            sclk_s3_q,  sclk_s3_d;
   logic            mosi_s1_q,  mosi_s1_d;
   logic            mosi_s2_q,  mosi_s2_d;
   logic [1:0]      settle_q,   settle_d;
   logic [CW-1:0]   bit_cnt_q,  bit_cnt_d;
   logic [DW-2:0]   rx_sh_q,    rx_sh_d;
   logic [DW-1:0]   tx_sh_q,    tx_sh_d;
   logic [DW-1:0]   rx_data_q,  rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            miso_oe_q,  miso_oe_d;
   logic            busy_q,     busy_d;

   logic            w_rise;
   logic            w_fall;
   logic            w_ss_fall;
   logic            w_ss_high;
   logic            w_tx_load;
   logic [DW-1:0]   w_rx_word;
   logic [DW-1:0]   w_tx_shifted;
   logic            w_miso_bit;

   // Edge and level detection on the synchronised pins
   assign w_rise    =  sclk_s2_q & ~sclk_s3_q;
   assign w_fall    = ~sclk_s2_q &  sclk_s3_q;
   assign w_ss_fall = ~ss_s2_q   &  ss_s3_q;
   assign w_ss_high =  ss_s2_q;

`ifdef SPI_SLV_LSB_FIRST_EN
   // LSB first: new bits enter at the top and walk down; MISO drives bit 0
   assign w_rx_word    = {mosi_s2_q, rx_sh_q};
   assign w_tx_shifted = {1'b0, tx_sh_q[DW-1:1]};
   assign w_miso_bit   = tx_sh_q[0];
`else
   // MSB first: new bits enter at the bottom; MISO drives the top bit
   assign w_rx_word    = {rx_sh_q, mosi_s2_q};
   assign w_tx_shifted = {tx_sh_q[DW-2:0], 1'b0};
   assign w_miso_bit   = tx_sh_q[DW-1];
`endif

   // Next-state logic for the synchronisers, protocol FSM and data paths
   always_comb begin
      state_d    = state_q;
      ss_s1_d    = spi_ss;
      ss_s2_d    = ss_s1_q;
      ss_s3_d    = ss_s2_q;
      sclk_s1_d  = spi_clk;
      sclk_s2_d  = sclk_s1_q;
      sclk_s3_d  = sclk_s2_q;
      mosi_s1_d  = spi_mosi;
      mosi_s2_d  = mosi_s1_q;
      settle_d   = settle_q;
      bit_cnt_d  = bit_cnt_q;
      rx_sh_d    = rx_sh_q;
      tx_sh_d    = tx_sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      w_tx_load  = 1'b0;

      case (state_q)
         // Synchroniser chain holds reset values for two cycles; only trust
         // ss once real pin samples have reached stage 2.
         ST_WAIT_IDLE: begin
            if (settle_q != 2'd2) begin
               settle_d = settle_q + 2'd1;
            end else if (w_ss_high) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (w_ss_fall) begin
               state_d   = ST_ACTIVE;
               bit_cnt_d = '0;
               w_tx_load = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (w_ss_high) begin
               // Deselect wins over any clock edge; partial words are dropped
               state_d   = ST_IDLE;
               bit_cnt_d = '0;
            end else if (w_rise) begin
               rx_sh_d = w_rx_word[DW-2:0];
`ifdef SPI_SLV_LSB_FIRST_EN
               rx_sh_d = w_rx_word[DW-1:1];
`endif
               if (bit_cnt_q == LAST_BIT) begin
                  rx_data_d  = w_rx_word;
                  rx_valid_d = 1'b1;
                  bit_cnt_d  = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + CW'(1);
               end
            end else if (w_fall) begin
               if (bit_cnt_q == '0) begin
                  w_tx_load = 1'b1;
               end else begin
                  tx_sh_d = w_tx_shifted;
               end
            end
         end
         default: begin
            state_d = ST_WAIT_IDLE;
         end
      endcase

      if (w_tx_load) begin
         tx_sh_d = tx_valid ? tx_data : DEF_TX;
      end

      busy_d    = (state_d == ST_ACTIVE);
      miso_oe_d = (state_d == ST_ACTIVE);
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_WAIT_IDLE;
         ss_s1_q    <= 1'b1;
         ss_s2_q    <= 1'b1;
         ss_s3_q    <= 1'b1;
         sclk_s1_q  <= 1'b0;
         sclk_s2_q  <= 1'b0;
         sclk_s3_q  <= 1'b0;
         mosi_s1_q  <= 1'b0;
         mosi_s2_q  <= 1'b0;
         settle_q   <= 2'd0;
         bit_cnt_q  <= '0;
         rx_sh_q    <= '0;
         tx_sh_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         miso_oe_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ss_s1_q    <= ss_s1_d;
         ss_s2_q    <= ss_s2_d;
         ss_s3_q    <= ss_s3_d;
         sclk_s1_q  <= sclk_s1_d;
         sclk_s2_q  <= sclk_s2_d;
         sclk_s3_q  <= sclk_s3_d;
         mosi_s1_q  <= mosi_s1_d;
         mosi_s2_q  <= mosi_s2_d;
         settle_q   <= settle_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_sh_q    <= rx_sh_d;
         tx_sh_q    <= tx_sh_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         miso_oe_q  <= miso_oe_d;
         busy_q     <= busy_d;
      end
   end

   // tx_ready marks the load cycle itself so tx_data is sampled with the strobe
   assign tx_ready    = w_tx_load & ~rst;
   assign spi_miso    = miso_oe_q & w_miso_bit;
   assign spi_miso_oe = miso_oe_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_rx_tx
// Description : Self-checking bench for spi_slave_rx_tx (DW=8 and DW=16
//               instances). Expected rx words and MISO words are queued when
//               a frame is started and popped as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_rx_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        spi_ss = 1'b1;
   logic        ss16 = 1'b1;
   logic        spi_clk = 1'b0;
   logic        spi_mosi = 1'b0;
   logic        spi_miso, spi_miso_oe, rx_valid, tx_ready, busy;
   logic [7:0]  rx_data;
   logic [7:0]  tx_data = 8'h00;
   logic        tx_valid = 1'b0;
   logic        miso16, miso_oe16, rx_valid16, tx_ready16, busy16;
   logic [15:0] rx_data16;
   logic [15:0] tx_data16 = 16'h1234;
   logic        tx_valid16 = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;
   int rv_cnt   = 0;
   int rv16_cnt = 0;
   int tr_cnt   = 0;
   logic rv_prev = 1'b0;

   logic [31:0] rx_q[$];
   logic [31:0] rx16_q[$];
   logic [31:0] miso_q[$];

   always #5 clk = ~clk;

   spi_slave_rx_tx #(.DW(8), .DEF_TX(8'hFF)) dut (
      .clk(clk), .rst(rst), .spi_ss(spi_ss), .spi_clk(spi_clk),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
   );

   spi_slave_rx_tx #(.DW(16), .DEF_TX(16'hFFFF)) dut16 (
      .clk(clk), .rst(rst), .spi_ss(ss16), .spi_clk(spi_clk),
      .spi_mosi(spi_mosi), .spi_miso(miso16), .spi_miso_oe(miso_oe16),
      .rx_data(rx_data16), .rx_valid(rx_valid16), .tx_data(tx_data16),
      .tx_valid(tx_valid16), .tx_ready(tx_ready16), .busy(busy16)
   );

   // Word <-> pin-order conversion (pins[n-1] is the first bit on the wire)
   function automatic logic [31:0] to_pins(input logic [31:0] w, input int n);
      logic [31:0] r;
      r = w;
`ifdef SPI_SLV_LSB_FIRST_EN
      r = '0;
      for (int i = 0; i < n; i++) r[n-1-i] = w[i];
`endif
      return r;
   endfunction

   // Received-word scoreboard and strobe monitors
   always @(negedge clk) begin
      logic [31:0] exp;
      if (rx_valid) begin
         rv_cnt++;
         n_checks++;
         if (rx_q.size() == 0) begin
            n_fail++;
            $display("FAIL rx_unexpected: rx_valid with rx_data=%h, none expected", rx_data);
         end else begin
            exp = rx_q.pop_front();
            if ({24'b0, rx_data} !== exp) begin
               n_fail++;
               $display("FAIL rx_data: got %h expected %h", rx_data, exp[7:0]);
            end
         end
         n_checks++;
         if (rv_prev !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_valid_width: rx_valid high %0d cycles, expected 1", 2);
         end
      end
      if (rx_valid16) begin
         rv16_cnt++;
         n_checks++;
         if (rx16_q.size() == 0) begin
            n_fail++;
            $display("FAIL rx16_unexpected: rx_valid with rx_data=%h, none expected", rx_data16);
         end else begin
            exp = rx16_q.pop_front();
            if ({16'b0, rx_data16} !== exp) begin
               n_fail++;
               $display("FAIL rx16_data: got %h expected %h", rx_data16, exp[15:0]);
            end
         end
      end
      if (tx_ready) tr_cnt++;
      rv_prev = rx_valid;
   end

   // Mode-0 master: drive n bits MSB of 'pins' first, sample MISO on rise
   task automatic spi_bits(input int n, input logic [31:0] pins, input bit sel16,
                           output logic [31:0] got);
      got = '0;
      for (int i = n - 1; i >= 0; i--) begin
         spi_mosi = pins[i];
         repeat (4) @(negedge clk);
         spi_clk = 1'b1;
         got[i]  = sel16 ? miso16 : spi_miso;
         repeat (4) @(negedge clk);
         spi_clk = 1'b0;
      end
   endtask

   task automatic select8();
      spi_ss = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic deselect8();
      repeat (4) @(negedge clk);
      spi_ss = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   // One 8-bit word on the DW=8 instance, MISO compared against the queue
   task automatic xfer_word(input logic [7:0] word, input string tag);
      logic [31:0] got, exp;
      rx_q.push_back({24'b0, word});
      spi_bits(8, to_pins({24'b0, word}, 8), 1'b0, got);
      exp = miso_q.pop_front();
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s_miso: got pins %h expected %h", tag, got[7:0], exp[7:0]);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({rx_data, rx_valid, tx_ready, spi_miso, spi_miso_oe, busy} !== 13'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rx_data=%h rv=%b tr=%b miso=%b oe=%b busy=%b expected all 0",
                  rx_data, rx_valid, tx_ready, spi_miso, spi_miso_oe, busy);
      end
      n_checks++;
      if ({busy16, miso_oe16, rx_valid16} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_dw16: got busy=%b oe=%b rv=%b expected 0", busy16, miso_oe16, rx_valid16);
      end
      rst = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_default_tx();
      int rv0;
      rv0 = rv_cnt; tr_cnt = 0;
      tx_valid = 1'b0;
      miso_q.push_back(to_pins(32'hFF, 8));
      select8();
      n_checks++;
      if ({busy, spi_miso_oe, spi_miso} !== 3'b111) begin
         n_fail++;
         $display("FAIL select_state: got busy=%b oe=%b miso=%b expected 1 1 1", busy, spi_miso_oe, spi_miso);
      end
      xfer_word(8'hA5, "default");
      deselect8();
      n_checks++;
      if (rv_cnt - rv0 !== 1 || rx_q.size() !== 0) begin
         n_fail++;
         $display("FAIL default_rx_count: got %0d strobes expected 1", rv_cnt - rv0);
      end
      n_checks++;
      if (tr_cnt !== 2) begin
         n_fail++;
         $display("FAIL default_tx_ready: got %0d pulses expected 2", tr_cnt);
      end
      n_checks++;
      if ({busy, spi_miso_oe} !== 2'b00) begin
         n_fail++;
         $display("FAIL deselect_state: got busy=%b oe=%b expected 0 0", busy, spi_miso_oe);
      end
   endtask

   task automatic test_back_to_back();
      int rv0;
      rv0 = rv_cnt; tr_cnt = 0;
      tx_data = 8'h3C; tx_valid = 1'b1;
      miso_q.push_back(to_pins(32'h3C, 8));
      miso_q.push_back(to_pins(32'h3C, 8));
      select8();
      xfer_word(8'h12, "b2b_0");
      xfer_word(8'h34, "b2b_1");
      deselect8();
      tx_valid = 1'b0;
      n_checks++;
      if (rv_cnt - rv0 !== 2 || rx_q.size() !== 0) begin
         n_fail++;
         $display("FAIL b2b_rx_count: got %0d strobes expected 2", rv_cnt - rv0);
      end
      n_checks++;
      if (tr_cnt !== 3) begin
         n_fail++;
         $display("FAIL b2b_tx_ready: got %0d pulses expected 3", tr_cnt);
      end
   endtask

   task automatic test_abort();
      int rv0;
      logic [31:0] got, exp;
      rv0 = rv_cnt;
      tx_valid = 1'b0;
      select8();
      exp = to_pins(32'hFF, 8) >> 3;
      spi_bits(5, 32'h1F, 1'b0, got);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL abort_miso: got pins %h expected %h", got, exp);
      end
      repeat (4) @(negedge clk);
      spi_ss = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({spi_miso_oe, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL abort_oe: got oe=%b busy=%b 3 clk after deselect, expected 0 0", spi_miso_oe, busy);
      end
      repeat (8) @(negedge clk);
      n_checks++;
      if (rv_cnt !== rv0) begin
         n_fail++;
         $display("FAIL abort_rx: got %0d strobes expected 0", rv_cnt - rv0);
      end
      miso_q.push_back(to_pins(32'hFF, 8));
      select8();
      xfer_word(8'h55, "after_abort");
      deselect8();
      n_checks++;
      if (rx_q.size() !== 0) begin
         n_fail++;
         $display("FAIL after_abort_rx: got %0d words pending expected 0", rx_q.size());
      end
   endtask

   task automatic test_reset_midframe();
      int rv0;
      logic [31:0] got, pins;
      tx_valid = 1'b0;
      pins = to_pins(32'hC3, 8);
      select8();
      spi_bits(3, pins >> 5, 1'b0, got);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({rx_data, rx_valid, spi_miso, spi_miso_oe, busy} !== 12'h0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got rx_data=%h rv=%b miso=%b oe=%b busy=%b expected all 0",
                  rx_data, rx_valid, spi_miso, spi_miso_oe, busy);
      end
      rv0 = rv_cnt;
      spi_bits(5, pins & 32'h1F, 1'b0, got);
      repeat (8) @(negedge clk);
      n_checks++;
      if (rv_cnt !== rv0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_ignore: got %0d strobes busy=%b expected 0 0", rv_cnt - rv0, busy);
      end
      spi_ss = 1'b1;
      repeat (10) @(negedge clk);
      miso_q.push_back(to_pins(32'hFF, 8));
      select8();
      xfer_word(8'hC3, "midreset");
      deselect8();
      n_checks++;
      if (rv_cnt - rv0 !== 1 || rx_q.size() !== 0) begin
         n_fail++;
         $display("FAIL midreset_rx_count: got %0d strobes expected 1", rv_cnt - rv0);
      end
   endtask

   task automatic test_bit_order();
      logic [31:0] got, exp;
      tx_data = 8'h80; tx_valid = 1'b1;
      exp = to_pins(32'h80, 8);
      rx_q.push_back(to_pins(32'h80, 8));
      select8();
      spi_bits(8, 32'h80, 1'b0, got);
      deselect8();
      tx_valid = 1'b0;
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL order_miso: got pins %h expected %h", got[7:0], exp[7:0]);
      end
      n_checks++;
      if (rx_q.size() !== 0) begin
         n_fail++;
         $display("FAIL order_rx: got %0d words pending expected 0", rx_q.size());
      end
   endtask

   task automatic test_dw16();
      logic [31:0] pins, exp, g_hi, g_lo, got;
      int rv0;
      rv0  = rv16_cnt;
      pins = to_pins(32'hBEEF, 16);
      exp  = to_pins(32'h1234, 16);
      rx16_q.push_back(32'hBEEF);
      ss16 = 1'b0;
      repeat (8) @(negedge clk);
      spi_bits(8, pins >> 8, 1'b1, g_hi);
      repeat (6) @(negedge clk);
      n_checks++;
      if (rv16_cnt !== rv0 || busy16 !== 1'b1) begin
         n_fail++;
         $display("FAIL dw16_mid: got %0d strobes busy=%b after 8 bits expected 0 1", rv16_cnt - rv0, busy16);
      end
      spi_bits(8, pins & 32'hFF, 1'b1, g_lo);
      got = {16'b0, g_hi[7:0], g_lo[7:0]};
      repeat (4) @(negedge clk);
      ss16 = 1'b1;
      repeat (10) @(negedge clk);
      n_checks++;
      if (rv16_cnt - rv0 !== 1 || rx16_q.size() !== 0) begin
         n_fail++;
         $display("FAIL dw16_rx_count: got %0d strobes expected 1", rv16_cnt - rv0);
      end
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL dw16_miso: got pins %h expected %h", got[15:0], exp[15:0]);
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_default_tx();
      test_back_to_back();
      test_abort();
      test_reset_midframe();
      test_bit_order();
      test_dw16();
      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
